// File: rtl/fpga_random_compare_checker.sv
// fpga_random_compare_checker
// LFSR-driven stimulus generator and masked output comparator for a fabric
// under test and its reference netlist. Runs IDLE -> WARMUP -> RUN -> DONE,
// counts mismatches (per cycle or per episode) and reports pass/fail.
module fpga_random_compare_checker #(
    parameter int                 NUM_IN        = 2,
    parameter int                 NUM_OUT       = 1,
    parameter int                 LFSR_W        = 32,
    parameter logic [LFSR_W-1:0]  SEED          = 32'h0000_0001,
    parameter int                 WARMUP_CYCLES = 1,
    parameter int                 RUN_CYCLES    = 400,
    parameter int                 CYC_W         = 16,
    parameter int                 ERR_W         = 16,
    parameter int                 COUNT_MODE    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [NUM_IN-1:0]  stim_o,
    input  logic [NUM_OUT-1:0] dut_out_i,
    input  logic [NUM_OUT-1:0] ref_out_i,
    input  logic [NUM_OUT-1:0] ref_mask_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [NUM_OUT-1:0] mismatch_flag,
    output logic [CYC_W-1:0]   first_err_cycle
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF =
        (SEED == {LFSR_W{1'b0}}) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

    // Taps 31,21,1,0 for the 32-bit register; other widths fall back to msb^lsb.
    localparam logic [LFSR_W-1:0] TAP_MASK =
        (LFSR_W == 32) ? LFSR_W'(32'h8020_0003)
                       : ({{(LFSR_W-1){1'b0}}, 1'b1} << (LFSR_W-1)) | {{(LFSR_W-1){1'b0}}, 1'b1};

    // Last counter value of each timed phase.
    localparam logic [CYC_W-1:0] WARM_LAST =
        (WARMUP_CYCLES == 0) ? {CYC_W{1'b0}} : CYC_W'(WARMUP_CYCLES - 1);
    localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(RUN_CYCLES - 1);

    // Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & TAP_MASK)};
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cur);
        logic [ERR_W-1:0] res;
        if (cur == {ERR_W{1'b1}}) begin
            res = cur;
        end else begin
            res = cur + ERR_W'(1);
        end
        return res;
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_s;
    logic [CYC_W-1:0]   cyc_r;
    logic [LFSR_W-1:0]  lfsr_r;
    logic               busy_r;
    logic               done_r;
    logic [ERR_W-1:0]   err_r;
    logic [NUM_OUT-1:0] flag_r;
    logic [CYC_W-1:0]   first_r;
    logic               prev_any_r;

    logic               start_ok_s;
    logic [NUM_OUT-1:0] mm_s;
    logic               any_s;
    logic               inc_s;
    logic               in_run_s;
    logic               in_warm_s;

    // Decode start acceptance, masked compare result and count-enable.
    always_comb begin
        in_run_s   = (state_r == ST_RUN);
        in_warm_s  = (state_r == ST_WARMUP);
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        mm_s       = (dut_out_i ^ ref_out_i) & ~ref_mask_i;
        any_s      = |mm_s;
        if (COUNT_MODE == 1) begin
            inc_s = in_run_s && any_s && !prev_any_r;
        end else begin
            inc_s = in_run_s && any_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE and DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WARMUP: begin
                if (cyc_r == WARM_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_WARMUP;
                end
            end
            ST_RUN: begin
                if (cyc_r == RUN_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_WARMUP) || (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Phase counter: counts warmup cycles, then doubles as the RUN index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r <= {CYC_W{1'b0}};
        end else if (start_ok_s) begin
            cyc_r <= {CYC_W{1'b0}};
        end else if (in_warm_s && (cyc_r == WARM_LAST)) begin
            cyc_r <= {CYC_W{1'b0}};
        end else if (in_warm_s || in_run_s) begin
            cyc_r <= cyc_r + CYC_W'(1);
        end else begin
            cyc_r <= cyc_r;
        end
    end

    // LFSR: reloaded on every accepted start, advances on every busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= SEED_EFF;
        end else if (start_ok_s) begin
            lfsr_r <= SEED_EFF;
        end else if (in_warm_s || in_run_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Episode history: cleared on start and on entry to RUN, tracks any in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_any_r <= 1'b0;
        end else if (start_ok_s || in_warm_s) begin
            prev_any_r <= 1'b0;
        end else if (in_run_s) begin
            prev_any_r <= any_s;
        end else begin
            prev_any_r <= prev_any_r;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= {ERR_W{1'b0}};
        end else if (start_ok_s) begin
            err_r <= {ERR_W{1'b0}};
        end else if (inc_s) begin
            err_r <= sat_inc(err_r);
        end else begin
            err_r <= err_r;
        end
    end

    // Sticky per-output mismatch flags, accumulated only in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_r <= {NUM_OUT{1'b0}};
        end else if (start_ok_s) begin
            flag_r <= {NUM_OUT{1'b0}};
        end else if (in_run_s) begin
            flag_r <= flag_r | mm_s;
        end else begin
            flag_r <= flag_r;
        end
    end

    // First mismatch index: the error count is still zero only before the
    // first mismatching RUN cycle, in either counting mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_r <= {CYC_W{1'b1}};
        end else if (start_ok_s) begin
            first_r <= {CYC_W{1'b1}};
        end else if (in_run_s && any_s && (err_r == {ERR_W{1'b0}})) begin
            first_r <= cyc_r;
        end else begin
            first_r <= first_r;
        end
    end

    assign stim_o          = busy_r ? lfsr_r[NUM_IN-1:0] : {NUM_IN{1'b0}};
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = done_r && (err_r == {ERR_W{1'b0}});
    assign err_count       = err_r;
    assign mismatch_flag   = flag_r;
    assign first_err_cycle = first_r;

endmodule

// File: tb/tb_fpga_random_compare_checker.sv
// Directed bench for fpga_random_compare_checker: three instances share
// clock/reset/start. u0 counts cycles (NUM_OUT=2), u1 counts episodes,
// u2 has a 2-bit error counter fed a constant mismatch.
module tb_fpga_random_compare_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [1:0]  d_dut  = 2'b00;
    logic [1:0]  d_ref  = 2'b00;
    logic [1:0]  d_mask = 2'b00;

    logic [1:0]  s0_stim, s1_stim;
    logic        s0_busy, s0_done, s0_pass;
    logic        s1_busy, s1_done, s1_pass;
    logic [15:0] s0_err, s1_err, s0_fec, s1_fec;
    logic [1:0]  s0_flag, s1_flag;

    logic        u2_dut  = 1'b1;
    logic        u2_ref  = 1'b0;
    logic        u2_mask = 1'b0;
    logic [1:0]  s2_stim;
    logic        s2_busy, s2_done, s2_pass;
    logic [1:0]  s2_err;
    logic        s2_flag;
    logic [15:0] s2_fec;

    int checks   = 0;
    int failures = 0;

    // Hand-derived LFSR low bits from SEED=1: 1,3,6,13,27,54,109,219,438
    logic [1:0] exp_stim [0:8] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11,
                                   2'b10, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    fpga_random_compare_checker #(
        .NUM_IN(2), .NUM_OUT(2), .WARMUP_CYCLES(1), .RUN_CYCLES(8),
        .CYC_W(16), .ERR_W(16), .COUNT_MODE(0)
    ) u0 (
        .clk(clk), .reset(reset), .start(start), .stim_o(s0_stim),
        .dut_out_i(d_dut), .ref_out_i(d_ref), .ref_mask_i(d_mask),
        .busy(s0_busy), .done(s0_done), .pass(s0_pass), .err_count(s0_err),
        .mismatch_flag(s0_flag), .first_err_cycle(s0_fec)
    );

    fpga_random_compare_checker #(
        .NUM_IN(2), .NUM_OUT(2), .WARMUP_CYCLES(1), .RUN_CYCLES(8),
        .CYC_W(16), .ERR_W(16), .COUNT_MODE(1)
    ) u1 (
        .clk(clk), .reset(reset), .start(start), .stim_o(s1_stim),
        .dut_out_i(d_dut), .ref_out_i(d_ref), .ref_mask_i(d_mask),
        .busy(s1_busy), .done(s1_done), .pass(s1_pass), .err_count(s1_err),
        .mismatch_flag(s1_flag), .first_err_cycle(s1_fec)
    );

    fpga_random_compare_checker #(
        .NUM_IN(2), .NUM_OUT(1), .WARMUP_CYCLES(1), .RUN_CYCLES(8),
        .CYC_W(16), .ERR_W(2), .COUNT_MODE(0)
    ) u2 (
        .clk(clk), .reset(reset), .start(start), .stim_o(s2_stim),
        .dut_out_i(u2_dut), .ref_out_i(u2_ref), .ref_mask_i(u2_mask),
        .busy(s2_busy), .done(s2_done), .pass(s2_pass), .err_count(s2_err),
        .mismatch_flag(s2_flag), .first_err_cycle(s2_fec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"},  32'(s0_busy), 32'd0);
        chk({tag, " done"},  32'(s0_done), 32'd0);
        chk({tag, " pass"},  32'(s0_pass), 32'd0);
        chk({tag, " err"},   32'(s0_err),  32'd0);
        chk({tag, " flag"},  32'(s0_flag), 32'd0);
        chk({tag, " fec"},   32'(s0_fec),  32'h0000_FFFF);
        chk({tag, " stim"},  32'(s0_stim), 32'd0);
        chk({tag, " u1err"}, 32'(s1_err),  32'd0);
        chk({tag, " u2err"}, 32'(s2_err),  32'd0);
        chk({tag, " u2stim"}, 32'(s2_stim), 32'd0);
        chk({tag, " u2fec"}, 32'(s2_fec),  32'h0000_FFFF);
    endtask

    // One full run: start pulse, then 9 busy cycles with the stim sequence
    // checked; err_idx bit k mismatches output bit 0 in RUN index k, masked
    // puts a persistent masked-off mismatch on bit 1; a start pulse is
    // applied while busy at ign_edge.
    task automatic do_run(input logic [7:0] err_idx, input logic masked, input int ign_edge);
        start  = 1'b1;
        d_dut  = 2'b00;
        d_ref  = 2'b00;
        d_mask = {masked, 1'b0};
        @(negedge clk);
        for (int e = 0; e <= 8; e++) begin
            chk($sformatf("stim[%0d]", e), 32'(s0_stim), 32'(exp_stim[e]));
            chk($sformatf("u1stim[%0d]", e), 32'(s1_stim), 32'(exp_stim[e]));
            chk($sformatf("busy[%0d]", e), 32'(s0_busy), 32'd1);
            chk($sformatf("done[%0d]", e), 32'(s0_done), 32'd0);
            if (e == 0) begin
                chk("u1busy", 32'(s1_busy), 32'd1);
                chk("u2busy", 32'(s2_busy), 32'd1);
                d_dut = {masked, 1'b0};
            end else begin
                d_dut = {masked, err_idx[e-1]};
            end
            start = (e == ign_edge);
            @(negedge clk);
        end
        start  = 1'b0;
        d_dut  = 2'b00;
        d_mask = 2'b00;
        chk("end done", 32'(s0_done), 32'd1);
        chk("end busy", 32'(s0_busy), 32'd0);
        chk("end stim", 32'(s0_stim), 32'd0);
        chk("u1 done",  32'(s1_done), 32'd1);
        chk("u2 done",  32'(s2_done), 32'd1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset("por");
        @(negedge clk);
        chk("idle done", 32'(s0_done), 32'd0);

        // Run A: clean, with a masked persistent mismatch on bit 1
        do_run(8'h00, 1'b1, -1);
        chk("A err",   32'(s0_err),  32'd0);
        chk("A pass",  32'(s0_pass), 32'd1);
        chk("A fec",   32'(s0_fec),  32'h0000_FFFF);
        chk("A flag",  32'(s0_flag), 32'd0);
        chk("A u1err", 32'(s1_err),  32'd0);
        chk("A u1pass", 32'(s1_pass), 32'd1);
        chk("A u2err", 32'(s2_err),  32'd3);
        chk("A u2pass", 32'(s2_pass), 32'd0);
        chk("A u2flag", 32'(s2_flag), 32'd1);
        chk("A u2fec", 32'(s2_fec),  32'd0);
        @(negedge clk);
        chk("A hold err", 32'(s2_err), 32'd3);
        chk("A hold done", 32'(s0_done), 32'd1);

        // Run B: restart from DONE, mismatch in RUN indices 3 and 4
        do_run(8'b0001_1000, 1'b0, -1);
        chk("B err",   32'(s0_err),  32'd2);
        chk("B fec",   32'(s0_fec),  32'd3);
        chk("B flag",  32'(s0_flag), 32'd1);
        chk("B pass",  32'(s0_pass), 32'd0);
        chk("B u1err", 32'(s1_err),  32'd1);
        chk("B u1fec", 32'(s1_fec),  32'd3);
        chk("B u1pass", 32'(s1_pass), 32'd0);

        // Run B2: episodes at indices 1, 4 and 6-7
        do_run(8'b1101_0010, 1'b0, -1);
        chk("B2 err",   32'(s0_err), 32'd4);
        chk("B2 fec",   32'(s0_fec), 32'd1);
        chk("B2 u1err", 32'(s1_err), 32'd3);

        // Run D: clean restart from DONE, start pulse while busy ignored
        do_run(8'h00, 1'b0, 3);
        chk("D err",   32'(s0_err),  32'd0);
        chk("D pass",  32'(s0_pass), 32'd1);
        chk("D fec",   32'(s0_fec),  32'h0000_FFFF);
        chk("D flag",  32'(s0_flag), 32'd0);
        chk("D u1err", 32'(s1_err),  32'd0);

        // Run C: mismatches in RUN 0..3, reset asserted in RUN index 4
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            d_dut = 2'b01;
            @(negedge clk);
        end
        d_dut = 2'b00;
        chk("C err pre", 32'(s0_err),  32'd4);
        chk("C busy pre", 32'(s0_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("C rst");
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
        end
        chk("C no report", 32'(s0_done), 32'd0);
        chk("C idle busy", 32'(s0_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
